// File: rtl/flappy_game_ctrl_pkg.sv
// Shared types and constants for the flappy bird game datapath.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int unsigned FLAP_STEP    = 70;
  localparam int unsigned GRAV_STEP    = 3;
  localparam int unsigned BIRD_Y_RESET = 380;
  localparam logic [9:0]  SCORE_MAX    = 10'd999;

  // Score increment that sticks at SCORE_MAX.
  function automatic logic [9:0] score_inc(input logic [9:0] s);
    return (s == SCORE_MAX) ? s : s + 10'd1;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Signals between the game sequencer and the bird/pipe datapath.
interface flappy_game_ctrl_if;
  logic        btn;
  logic [11:0] bird_y;
  logic        collide;
  logic        pass;
  logic        bird_rstn;
  logic        bird_en;
  logic        bird_move;
  logic        running;
  logic [1:0]  game_state;
  logic [9:0]  score;

  // Sequencer side.
  modport master (
    input  btn, bird_y, collide, pass,
    output bird_rstn, bird_en, bird_move, running, game_state, score
  );

  // Datapath / player side.
  modport slave (
    output btn, bird_y, collide, pass,
    input  bird_rstn, bird_en, bird_move, running, game_state, score
  );
endinterface

// File: rtl/flappy_game_ctrl_btn_sync_edge.sv
// Synchronises an asynchronous level input and emits a registered
// single-cycle pulse on each rising edge.
module btn_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  // Two-flop synchroniser, edge-history flop and registered rise pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: IDLE/PLAY/DEAD state machine, gravity divider, flap
// cooldown, death hold-off and score keeping for the bird datapath.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned GRAV_DIV      = 250000,
  parameter int unsigned FLAP_COOLDOWN = 12,
  parameter int unsigned Y_CEIL        = 0,
  parameter int unsigned Y_FLOOR       = 700,
  parameter int unsigned DEAD_HOLD     = 50000000
) (
  input logic               clk,
  input logic               rstn,
  flappy_game_ctrl_if.master bus
);

  localparam int unsigned DIV_W  = $clog2(GRAV_DIV);
  localparam int unsigned COOL_W = $clog2(FLAP_COOLDOWN + 2);
  localparam int unsigned HOLD_W = $clog2(DEAD_HOLD + 2);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(GRAV_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(FLAP_COOLDOWN);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(DEAD_HOLD);
  localparam logic [11:0]       FLAP_MIN  = 12'(Y_CEIL + FLAP_STEP);
  localparam logic [11:0]       FLOOR_Y   = 12'(Y_FLOOR);

  logic btn_rise;

  btn_sync_edge u_btn_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (bus.btn),
    .rise (btn_rise)
  );

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [9:0]        score_q, score_d;
  logic              pend_q, pend_d;
  logic              death_q, death_d;
  logic              en_q, en_d;
  logic              move_q, move_d;
  logic              brstn_q, run_q;
  logic              wrap, flap_ok;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cool_d  = cool_q;
    hold_d  = hold_q;
    score_d = score_q;
    pend_d  = 1'b0;
    death_d = 1'b0;
    en_d    = 1'b0;
    move_d  = 1'b0;
    wrap    = (div_q == DIV_LAST);
    flap_ok = btn_rise && (cool_q == '0) && (bus.bird_y >= FLAP_MIN);

    case (state_q)
      IDLE: begin
        div_d  = '0;
        cool_d = '0;
        hold_d = '0;
        if (btn_rise) begin
          state_d = PLAY;
          score_d = '0;
        end
      end

      PLAY: begin
        div_d   = wrap ? '0 : div_q + DIV_W'(1);
        death_d = bus.collide || (bus.bird_y >= FLOOR_Y);
        if (death_q) begin
          // Death registered last cycle pre-empts flap, tick and pass.
          state_d = DEAD;
          hold_d  = '0;
        end else begin
          if (wrap && (cool_q != '0))
            cool_d = cool_q - COOL_W'(1);
          if (flap_ok) begin
            move_d = 1'b1;
            cool_d = COOL_LOAD;
          end
          // A tick colliding with a flap is parked for one cycle so the
          // generator, which favours the move, still sees it.
          if (pend_q)
            en_d = 1'b1;
          else if (wrap) begin
            if (flap_ok) pend_d = 1'b1;
            else         en_d   = 1'b1;
          end
          if (bus.pass)
            score_d = score_inc(score_q);
        end
      end

      DEAD: begin
        if (hold_q != HOLD_MAX)
          hold_d = hold_q + HOLD_W'(1);
        else if (btn_rise)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      div_q   <= '0;
      cool_q  <= '0;
      hold_q  <= '0;
      score_q <= '0;
      pend_q  <= 1'b0;
      death_q <= 1'b0;
      en_q    <= 1'b0;
      move_q  <= 1'b0;
      brstn_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cool_q  <= cool_d;
      hold_q  <= hold_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      death_q <= death_d;
      en_q    <= en_d;
      move_q  <= move_d;
      brstn_q <= (state_d != IDLE);
      run_q   <= (state_d == PLAY);
    end
  end

  assign bus.bird_rstn  = brstn_q;
  assign bus.bird_en    = en_q;
  assign bus.bird_move  = move_q;
  assign bus.running    = run_q;
  assign bus.game_state = state_q;
  assign bus.score      = score_q;

endmodule
